// File: rtl/retire_controller_pkg.sv
// retire_controller_pkg
//   Shared core constants for the active-list (AL) retire logic.
//   AL_SIZE comes from the `AL_SIZE define, which is the only place the value
//   is set. AL_IDX_W is the AL index width. RETIRE_WIDTH and WB_PORTS are the
//   retire and writeback widths of the core.
`ifndef AL_SIZE
`define AL_SIZE 32
`endif

package retire_controller_pkg;
  localparam int AL_SIZE      = `AL_SIZE;
  localparam int AL_IDX_W     = $clog2(AL_SIZE);
  localparam int RETIRE_WIDTH = 2;
  localparam int WB_PORTS     = 4;
endpackage

// File: rtl/retire_controller_al_range_mask.sv
// al_range_mask
//   Combinational wrapped range mask over the active list.
//   o_mask[i] = 1 when index i lies in [i_start, i_end) modulo N.
//   i_start == i_end gives an empty mask.
// Ports:
//   i_start  first index of the range
//   i_end    one past the last index of the range
//   o_mask   N-bit membership mask
module al_range_mask
  import retire_controller_pkg::*;
#(
  parameter int N = AL_SIZE
) (
  input  logic [$clog2(N)-1:0] i_start,
  input  logic [$clog2(N)-1:0] i_end,
  output logic [N-1:0]         o_mask
);
  localparam int W = $clog2(N);

  // Range length and per-index offset from start, both modulo N; an index is
  // inside when its offset is below the length. No explicit wrap case needed.
  logic [W-1:0] w_len;
  assign w_len = i_end - i_start;

  for (genvar i = 0; i < N; i++) begin : g_bit
    logic [W-1:0] w_off;
    assign w_off     = W'(i) - i_start;
    assign o_mask[i] = (w_off < w_len);
  end
endmodule

// File: rtl/retire_controller.sv
// retire_controller
//   In-order retirement from the active list. Records writeback completion in a
//   done bit vector, retires up to two oldest completed entries per cycle, owns
//   the AL back pointer and a retirement counter, and squashes completion state
//   on a branch recall.
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   al_front_ptr    next free AL slot (from rename)
//   wb_valid        per-port writeback valid
//   wb_al_idx       per-port completing AL index, port p at [p*W +: W]
//   if_recall       branch mispredict recall
//   new_front       first squashed AL index on recall
//   al_back_ptr     oldest unretired entry (registered)
//   retire_valid    per-slot retire strobe, [1] implies [0] (combinational)
//   retire_al_idx   per-slot retiring index, slot s at [s*W +: W]
//   retired_count   total retirements since reset (registered, wraps)
module retire_controller #(
  parameter int AL_SIZE      = retire_controller_pkg::AL_SIZE,
  parameter int WB_PORTS     = retire_controller_pkg::WB_PORTS,
  parameter int RETIRE_WIDTH = retire_controller_pkg::RETIRE_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [$clog2(AL_SIZE)-1:0]            al_front_ptr,
  input  logic [WB_PORTS-1:0]                   wb_valid,
  input  logic [WB_PORTS*$clog2(AL_SIZE)-1:0]   wb_al_idx,
  input  logic                                  if_recall,
  input  logic [$clog2(AL_SIZE)-1:0]            new_front,
  output logic [$clog2(AL_SIZE)-1:0]            al_back_ptr,
  output logic [RETIRE_WIDTH-1:0]               retire_valid,
  output logic [RETIRE_WIDTH*$clog2(AL_SIZE)-1:0] retire_al_idx,
  output logic [31:0]                           retired_count
);
  localparam int W = $clog2(AL_SIZE);

  logic [AL_SIZE-1:0] r_done;
  logic [W-1:0]       r_back;
  logic [31:0]        r_count;

  logic [AL_SIZE-1:0] w_occ_mask;
  logic [AL_SIZE-1:0] w_squash_mask;
  logic [AL_SIZE-1:0] w_wb_set;
  logic [AL_SIZE-1:0] w_retire_clr;
  logic [AL_SIZE-1:0] w_done_next;
  logic [W-1:0]       w_back1;
  logic               w_fire0;
  logic               w_fire1;
  logic [1:0]         w_retire_n;

  // Occupied window [back, front): writebacks outside it are dropped.
  al_range_mask #(.N(AL_SIZE)) u_occ_mask (
    .i_start (r_back),
    .i_end   (al_front_ptr),
    .o_mask  (w_occ_mask)
  );

  // Squashed window [new_front, front) cleared on recall.
  al_range_mask #(.N(AL_SIZE)) u_squash_mask (
    .i_start (new_front),
    .i_end   (al_front_ptr),
    .o_mask  (w_squash_mask)
  );

  assign w_back1 = r_back + W'(1);

  // Retire is suppressed during reset and recall so nothing downstream acts on
  // an entry whose state is about to be discarded.
  assign w_fire0 = !reset && !if_recall && (r_back != al_front_ptr) && r_done[r_back];
  assign w_fire1 = w_fire0 && (w_back1 != al_front_ptr) && r_done[w_back1];

  assign w_retire_n = {1'b0, w_fire0} + {1'b0, w_fire1};

  always_comb begin
    w_wb_set = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid[p]) w_wb_set[wb_al_idx[p*W +: W]] = 1'b1;
    end
  end

  always_comb begin
    w_retire_clr = '0;
    if (w_fire0) w_retire_clr[r_back]  = 1'b1;
    if (w_fire1) w_retire_clr[w_back1] = 1'b1;
  end

  // Clears are applied after sets so recall squash wins over a same-cycle
  // writeback to a squashed index.
  always_comb begin
    w_done_next = (r_done | (w_wb_set & w_occ_mask)) & ~w_retire_clr;
    if (if_recall) w_done_next = w_done_next & ~w_squash_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_done  <= '0;
      r_back  <= '0;
      r_count <= '0;
    end else begin
      r_done  <= w_done_next;
      r_back  <= r_back + W'(w_retire_n);
      r_count <= r_count + 32'(w_retire_n);
    end
  end

  assign al_back_ptr   = r_back;
  assign retired_count = r_count;
  assign retire_valid  = {w_fire1, w_fire0};
  assign retire_al_idx = {w_back1, r_back};
endmodule

// File: tb/tb_retire_controller.sv
module tb_retire_controller;
  localparam int W = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  al_front_ptr;
  logic [3:0]    wb_valid;
  logic [4*W-1:0] wb_al_idx;
  logic          if_recall;
  logic [W-1:0]  new_front;
  logic [W-1:0]  al_back_ptr;
  logic [1:0]    retire_valid;
  logic [2*W-1:0] retire_al_idx;
  logic [31:0]   retired_count;

  int checks = 0;
  int errors = 0;

  retire_controller dut (
    .clk           (clk),
    .reset         (reset),
    .al_front_ptr  (al_front_ptr),
    .wb_valid      (wb_valid),
    .wb_al_idx     (wb_al_idx),
    .if_recall     (if_recall),
    .new_front     (new_front),
    .al_back_ptr   (al_back_ptr),
    .retire_valid  (retire_valid),
    .retire_al_idx (retire_al_idx),
    .retired_count (retired_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic drive_wb(input int p, input int idx);
    logic [W-1:0] v;
    v = idx[W-1:0];
    wb_valid[p] = 1'b1;
    wb_al_idx[p*W +: W] = v;
  endtask

  task automatic clear_wb();
    wb_valid  = '0;
    wb_al_idx = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_wb();
    if_recall    = 1'b0;
    new_front    = '0;
    al_front_ptr = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_wb();
    if_recall = 1'b0; new_front = '0; al_front_ptr = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++; if (al_back_ptr !== 5'd0) begin errors++; $display("FAIL reset_back got %0d exp 0", al_back_ptr); end
    checks++; if (retired_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", retired_count); end
    checks++; if (retire_valid !== 2'b00) begin errors++; $display("FAIL reset_rv got %b exp 00", retire_valid); end
  endtask

  task automatic test_basic();
    do_reset();
    al_front_ptr = 5'd3;
    drive_wb(0, 0); drive_wb(2, 1);
    #1;
    checks++; if (retire_valid !== 2'b00) begin errors++; $display("FAIL basic_pre_rv got %b exp 00", retire_valid); end
    tick(); clear_wb(); #1;
    checks++; if (retire_valid !== 2'b11) begin errors++; $display("FAIL basic_rv got %b exp 11", retire_valid); end
    checks++; if (retire_al_idx !== {5'd1, 5'd0}) begin errors++; $display("FAIL basic_idx got %h exp %h", retire_al_idx, {5'd1, 5'd0}); end
    checks++; if (al_back_ptr !== 5'd0) begin errors++; $display("FAIL basic_back_hold got %0d exp 0", al_back_ptr); end
    tick(); #1;
    checks++; if (al_back_ptr !== 5'd2) begin errors++; $display("FAIL basic_back got %0d exp 2", al_back_ptr); end
    checks++; if (retired_count !== 32'd2) begin errors++; $display("FAIL basic_count got %0d exp 2", retired_count); end
    checks++; if (retire_valid !== 2'b00) begin errors++; $display("FAIL basic_idle_rv got %b exp 00", retire_valid); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    al_front_ptr = 5'd4;
    drive_wb(1, 2);
    tick(); clear_wb(); drive_wb(3, 1); #1;
    checks++; if (retire_valid !== 2'b00) begin errors++; $display("FAIL ooo_wait1 got %b exp 00", retire_valid); end
    tick(); clear_wb(); drive_wb(0, 0); #1;
    checks++; if (retire_valid !== 2'b00) begin errors++; $display("FAIL ooo_wait2 got %b exp 00", retire_valid); end
    tick(); clear_wb(); #1;
    checks++; if (retire_valid !== 2'b11 || retire_al_idx !== {5'd1, 5'd0}) begin errors++; $display("FAIL ooo_r01 got %b/%h exp 11/%h", retire_valid, retire_al_idx, {5'd1, 5'd0}); end
    tick(); #1;
    checks++; if (retire_valid !== 2'b01 || retire_al_idx[W-1:0] !== 5'd2) begin errors++; $display("FAIL ooo_r2 got %b/%0d exp 01/2", retire_valid, retire_al_idx[W-1:0]); end
    tick(); #1;
    checks++; if (al_back_ptr !== 5'd3 || retire_valid !== 2'b00) begin errors++; $display("FAIL ooo_back got %0d/%b exp 3/00", al_back_ptr, retire_valid); end
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    al_front_ptr = 5'd31;
    // Index 31 is unoccupied here, so its writeback must be dropped.
    for (int b = 0; b < 32; b += 4) begin
      for (int p = 0; p < 4; p++) drive_wb(p, b + p);
      tick();
    end
    clear_wb();
    n = 0;
    while (al_back_ptr !== 5'd31 && n < 40) begin tick(); n++; end
    checks++; if (al_back_ptr !== 5'd31) begin errors++; $display("FAIL wrap_reach31 got %0d exp 31 (timeout)", al_back_ptr); end
    checks++; if (retired_count !== 32'd31) begin errors++; $display("FAIL wrap_count31 got %0d exp 31", retired_count); end
    al_front_ptr = 5'd1; #1;
    checks++; if (retire_valid !== 2'b00) begin errors++; $display("FAIL wrap_filter got %b exp 00", retire_valid); end
    drive_wb(0, 31); drive_wb(2, 0);
    tick(); clear_wb(); #1;
    checks++; if (retire_valid !== 2'b11 || retire_al_idx !== {5'd0, 5'd31}) begin errors++; $display("FAIL wrap_idx got %b/%h exp 11/%h", retire_valid, retire_al_idx, {5'd0, 5'd31}); end
    tick(); #1;
    checks++; if (al_back_ptr !== 5'd1) begin errors++; $display("FAIL wrap_back got %0d exp 1", al_back_ptr); end
    checks++; if (retired_count !== 32'd33) begin errors++; $display("FAIL wrap_count got %0d exp 33", retired_count); end
  endtask

  task automatic test_recall();
    do_reset();
    al_front_ptr = 5'd8;
    drive_wb(0, 2); drive_wb(1, 5); drive_wb(2, 6);
    tick(); clear_wb();
    if_recall = 1'b1; new_front = 5'd4;
    drive_wb(0, 3); drive_wb(1, 7);
    #1;
    checks++; if (retire_valid !== 2'b00) begin errors++; $display("FAIL recall_rv got %b exp 00", retire_valid); end
    tick(); clear_wb();
    if_recall = 1'b0; new_front = '0; al_front_ptr = 5'd4;
    drive_wb(1, 0); drive_wb(3, 1);
    tick(); clear_wb(); #1;
    checks++; if (retire_valid !== 2'b11 || retire_al_idx !== {5'd1, 5'd0}) begin errors++; $display("FAIL recall_r01 got %b/%h exp 11/%h", retire_valid, retire_al_idx, {5'd1, 5'd0}); end
    tick(); #1;
    checks++; if (retire_valid !== 2'b11 || retire_al_idx !== {5'd3, 5'd2}) begin errors++; $display("FAIL recall_r23 got %b/%h exp 11/%h", retire_valid, retire_al_idx, {5'd3, 5'd2}); end
    tick(); #1;
    checks++; if (al_back_ptr !== 5'd4 || retire_valid !== 2'b00) begin errors++; $display("FAIL recall_back got %0d/%b exp 4/00", al_back_ptr, retire_valid); end
    // Reallocate 4..7: only freshly written entries may retire.
    al_front_ptr = 5'd8;
    drive_wb(0, 4);
    tick(); clear_wb(); #1;
    checks++; if (retire_valid !== 2'b01 || retire_al_idx[W-1:0] !== 5'd4) begin errors++; $display("FAIL recall_done5 got %b exp 01", retire_valid); end
    drive_wb(0, 5);
    tick(); clear_wb(); #1;
    checks++; if (retire_valid !== 2'b01 || retire_al_idx[W-1:0] !== 5'd5) begin errors++; $display("FAIL recall_done6 got %b exp 01", retire_valid); end
    drive_wb(0, 6);
    tick(); clear_wb(); #1;
    checks++; if (retire_valid !== 2'b01 || retire_al_idx[W-1:0] !== 5'd6) begin errors++; $display("FAIL recall_done7 got %b exp 01", retire_valid); end
    tick(); #1;
    checks++; if (al_back_ptr !== 5'd7 || retire_valid !== 2'b00) begin errors++; $display("FAIL recall_end got %0d/%b exp 7/00", al_back_ptr, retire_valid); end
  endtask

  task automatic test_recall_suppress();
    do_reset();
    al_front_ptr = 5'd2;
    drive_wb(0, 0);
    tick(); clear_wb();
    if_recall = 1'b1; new_front = 5'd2;
    #1;
    checks++; if (retire_valid !== 2'b00) begin errors++; $display("FAIL suppress_rv got %b exp 00", retire_valid); end
    tick();
    if_recall = 1'b0; #1;
    checks++; if (al_back_ptr !== 5'd0) begin errors++; $display("FAIL suppress_back got %0d exp 0", al_back_ptr); end
    checks++; if (retire_valid !== 2'b01 || retire_al_idx[W-1:0] !== 5'd0) begin errors++; $display("FAIL suppress_after got %b exp 01", retire_valid); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    al_front_ptr = 5'd4;
    drive_wb(0, 0); drive_wb(1, 1);
    tick(); clear_wb(); #1;
    checks++; if (retire_valid !== 2'b11) begin errors++; $display("FAIL midrst_pre got %b exp 11", retire_valid); end
    reset = 1'b1;
    drive_wb(2, 2);
    #1;
    checks++; if (retire_valid !== 2'b00) begin errors++; $display("FAIL midrst_rv got %b exp 00", retire_valid); end
    tick(); clear_wb(); reset = 1'b0; #1;
    checks++; if (al_back_ptr !== 5'd0) begin errors++; $display("FAIL midrst_back got %0d exp 0", al_back_ptr); end
    checks++; if (retired_count !== 32'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", retired_count); end
    checks++; if (retire_valid !== 2'b00) begin errors++; $display("FAIL midrst_done got %b exp 00", retire_valid); end
  endtask

  initial begin
    reset = 1'b1;
    al_front_ptr = '0;
    wb_valid = '0;
    wb_al_idx = '0;
    if_recall = 1'b0;
    new_front = '0;
    test_reset();
    test_basic();
    test_out_of_order();
    test_wrap();
    test_recall();
    test_recall_suppress();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
